axi_full_mst_burst: RTL and testbench
=====================================

// Module: axi_full_mst_burst
// PURPOSE
//  AXI4 full-protocol initiator for the simulation top. It turns a simple command/data stream into
//  single-ID INCR bursts toward an AXI4 responder (e.g. the axi_full_slv_sram memory model).
//  Lets a bench preload and read back SRAM over the bus instead of by backdoor.
//  At most one transaction is outstanding; write = AW, then W beats, then B; read = AR, then R beats.
// PARAMETERS
//  DW      64  data width in bits (32/64/128); AXI size = log2(DW/8), fixed
//  AW      32  address width
//  IDW     4   ID width
//  TXID    0   ID driven on AWID/ARID; the only ID accepted on BID/RID
// PORTS
//  CLK          in   1        clock
//  RSTn         in   1        asynchronous active-low reset
//  cmd_valid    in   1        command request
//  cmd_ready    out  1        high only in IDLE
//  cmd_write    in   1        1=write burst, 0=read burst
//  cmd_addr     in   AW       start address, DW/8-aligned
//  cmd_len      in   8        beats-1 (AXI LEN encoding)
//  wd_valid     in   1        write-data beat available
//  wd_ready     out  1        = MEM_WREADY while in W state
//  wd_data      in   DW       write-data beat
//  wd_strb      in   DW/8     write-data byte strobes
//  rd_valid     out  1        = MEM_RVALID while in R state
//  rd_ready     in   1        drives MEM_RREADY in R state
//  rd_data      out  DW       = MEM_RDATA
//  rd_last      out  1        high on the beat where beat counter == latched len
//  done_valid   out  1        one-cycle pulse when a command completes
//  done_resp    out  2        worst (max) BRESP/RRESP of the burst, or local error code
//  done_err     out  1        protocol error (ID mismatch, misplaced RLAST, 4KB crossing, misalignment)
//  MEM_AW*/W*/B*/AR*/R*  AXI4 initiator side: ID, ADDR, LEN, SIZE, BURST, VALID/READY, WDATA, WSTRB,
//                        WLAST, BRESP, RDATA, RRESP, RLAST; widths per the parameters
// BEHAVIOUR
//  Reset values: all VALIDs 0; BREADY/RREADY 0; cmd_ready 1; done_valid 0; done_resp 0; done_err 0;
//    addr/len/count registers 0.
//  FSM states: IDLE, AWR, WDAT, BRSP, ARD, RDAT, DONE.
//  IDLE: cmd_valid & cmd_ready latches addr/len/write. The next state is AWR or ARD.
//    A command where addr[11:0] + (len+1)*DW/8 > 4096, or addr is not DW/8-aligned, goes to DONE
//    with done_resp=2'b10 and done_err=1. No bus activity occurs for such a command.
//  AWR/ARD: AWVALID/ARVALID rises the cycle after acceptance and holds with stable fields until READY.
//    BURST=2'b01 (INCR), ID=TXID. Lock, cache, prot and qos are tied to 0.
//  WDAT: WVALID = wd_valid and WREADY = wd_ready, combinationally passed through; no buffering.
//    The beat counter increments on each WVALID&WREADY. WLAST = (count==len).
//    On the last handshake, go to BRSP.
//  BRSP: BREADY=1. On BVALID, done_resp=BRESP and done_err=(BID!=TXID). Go to DONE.
//  RDAT: the beat counter increments on RVALID&RREADY. done_resp is tracked as the running max of RRESP.
//    RLAST with count!=len, or count==len without RLAST, or RID!=TXID sets sticky done_err.
//    Leave on the beat where count==len; the burst is never extended past len+1 beats.
//  DONE: done_valid=1 for exactly one cycle, then IDLE. cmd_ready is 0 during DONE.
//  Latency: zero-wait responder with len=0 write gives cmd accept(t) -> AWVALID(t+1) -> W beat(t+2)
//    -> B(t+3) -> done_valid(t+4).
//  Counter is 8-bit; len=255 needs 256 beats and no wrap occurs before WLAST/RLAST.
//  Simultaneous events: a new cmd_valid during DONE is not accepted until IDLE.
//    wd_valid outside WDAT is ignored (wd_ready=0).
//  RSTn assertion mid-burst aborts immediately to IDLE with all VALIDs low. The responder is not
//    drained; the bench must reset the responder as well.
// STRUCTURE
//  Shared package axi_pkg: AXI BURST/RESP encodings (INCR, OKAY, EXOKAY, SLVERR, DECERR) and the FSM
//    state enum. Both are shared with the SRAM model and the debugger.
//  One sub-module, axi_beat_cnt: 8-bit beat counter with clear/inc and an is_last compare.
//  Everything else is flat.
// TESTING
//  T1 write addr=0x80000000, len=3, data 0x11..0x44, strb all-ones -> 4 W beats, WLAST only on the
//     4th beat; done_resp=0, done_err=0. SRAM words 0..3 hold 0x11..0x44.
//  T2 read addr=0x80000000, len=3 after T1 -> rd_data 0x11,0x22,0x33,0x44; rd_last on 4th beat;
//     done_resp=0.
//  T3 read len=7 with rd_ready toggling 1/0 every cycle -> 8 beats and no lost or duplicate data;
//     exactly one done_valid.
//  T4 write addr=0x80000FF8, len=1, DW=64 (crosses 4KB) -> no AWVALID ever;
//     done_valid 2 cycles after accept with done_resp=2'b10, done_err=1.
//  T5 responder returns RRESP=2'b10 on beat 2 of 4 -> done_resp=2'b10.
//     Early RLAST on beat 1 -> done_err=1.
//  T6 RSTn low for 1 cycle during WDAT beat 2 of len=7 -> all VALIDs 0 and cmd_ready=1 immediately;
//     a subsequent len=0 write completes with done_resp=0.

Source files
------------

// File: rtl/axi_pkg.sv
// AXI encodings and the initiator FSM state enum, shared with the SRAM model and the debugger.
package axi_pkg;

    localparam logic [1:0] AXI_BURST_INCR  = 2'b01;
    localparam logic [1:0] AXI_RESP_OKAY   = 2'b00;
    localparam logic [1:0] AXI_RESP_EXOKAY = 2'b01;
    localparam logic [1:0] AXI_RESP_SLVERR = 2'b10;
    localparam logic [1:0] AXI_RESP_DECERR = 2'b11;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_AWR,
        ST_WDAT,
        ST_BRSP,
        ST_ARD,
        ST_RDAT,
        ST_DONE
    } mst_state_e;

    function automatic logic [1:0] resp_max(input logic [1:0] a, input logic [1:0] b);
        return (a > b) ? a : b;
    endfunction

endpackage

// File: rtl/axi_beat_cnt.sv
// 8-bit burst beat counter; is_last flags the beat whose index equals the latched AXI LEN.
module axi_beat_cnt (
    input  logic       CLK,
    input  logic       RSTn,
    input  logic       clr,
    input  logic       inc,
    input  logic [7:0] len,
    output logic       is_last
);

    logic [7:0] cnt;

    always_ff @(posedge CLK or negedge RSTn) begin
        if (!RSTn)    cnt <= 8'd0;
        else if (clr) cnt <= 8'd0;
        else if (inc) cnt <= cnt + 8'd1;
    end

    assign is_last = (cnt == len);

endmodule

// File: rtl/axi_full_mst_burst.sv
// Single-outstanding AXI4 INCR-burst initiator driven by a simple command / data stream.
module axi_full_mst_burst
    import axi_pkg::*;
#(
    parameter int             DW   = 64,
    parameter int             AW   = 32,
    parameter int             IDW  = 4,
    parameter logic [IDW-1:0] TXID = '0
) (
    input  logic              CLK,
    input  logic              RSTn,
    input  logic              cmd_valid,
    output logic              cmd_ready,
    input  logic              cmd_write,
    input  logic [AW-1:0]     cmd_addr,
    input  logic [7:0]        cmd_len,
    input  logic              wd_valid,
    output logic              wd_ready,
    input  logic [DW-1:0]     wd_data,
    input  logic [DW/8-1:0]   wd_strb,
    output logic              rd_valid,
    input  logic              rd_ready,
    output logic [DW-1:0]     rd_data,
    output logic              rd_last,
    output logic              done_valid,
    output logic [1:0]        done_resp,
    output logic              done_err,
    output logic [IDW-1:0]    MEM_AWID,
    output logic [AW-1:0]     MEM_AWADDR,
    output logic [7:0]        MEM_AWLEN,
    output logic [2:0]        MEM_AWSIZE,
    output logic [1:0]        MEM_AWBURST,
    output logic              MEM_AWLOCK,
    output logic [3:0]        MEM_AWCACHE,
    output logic [2:0]        MEM_AWPROT,
    output logic [3:0]        MEM_AWQOS,
    output logic              MEM_AWVALID,
    input  logic              MEM_AWREADY,
    output logic [DW-1:0]     MEM_WDATA,
    output logic [DW/8-1:0]   MEM_WSTRB,
    output logic              MEM_WLAST,
    output logic              MEM_WVALID,
    input  logic              MEM_WREADY,
    input  logic [IDW-1:0]    MEM_BID,
    input  logic [1:0]        MEM_BRESP,
    input  logic              MEM_BVALID,
    output logic              MEM_BREADY,
    output logic [IDW-1:0]    MEM_ARID,
    output logic [AW-1:0]     MEM_ARADDR,
    output logic [7:0]        MEM_ARLEN,
    output logic [2:0]        MEM_ARSIZE,
    output logic [1:0]        MEM_ARBURST,
    output logic              MEM_ARLOCK,
    output logic [3:0]        MEM_ARCACHE,
    output logic [2:0]        MEM_ARPROT,
    output logic [3:0]        MEM_ARQOS,
    output logic              MEM_ARVALID,
    input  logic              MEM_ARREADY,
    input  logic [IDW-1:0]    MEM_RID,
    input  logic [DW-1:0]     MEM_RDATA,
    input  logic [1:0]        MEM_RRESP,
    input  logic              MEM_RLAST,
    input  logic              MEM_RVALID,
    output logic              MEM_RREADY
);

    localparam int         SB     = DW / 8;
    localparam int         AL     = $clog2(SB);
    localparam logic [2:0] AXSIZE = 3'(AL);

    mst_state_e    state;
    logic [AW-1:0] addr_q;
    logic [7:0]    len_q;
    logic          bad_q;
    logic          awvalid_q;
    logic          arvalid_q;
    logic          done_q;
    logic [1:0]    resp_q;
    logic          err_q;
    logic          is_last;
    logic          w_hs;
    logic          r_hs;
    logic [13:0]   end_off;
    logic          cmd_bad;

    // 14 bits hold the worst case 4095 + 256*16 without overflow
    always_comb begin
        end_off = 14'(cmd_addr[11:0]) + (14'(cmd_len) + 14'd1) * 14'(SB);
        cmd_bad = (end_off > 14'd4096) || (cmd_addr[AL-1:0] != '0);
    end

    assign w_hs = (state == ST_WDAT) && wd_valid && MEM_WREADY;
    assign r_hs = (state == ST_RDAT) && MEM_RVALID && rd_ready;

    axi_beat_cnt u_beat_cnt (
        .CLK     (CLK),
        .RSTn    (RSTn),
        .clr     (cmd_valid && cmd_ready),
        .inc     (w_hs || r_hs),
        .len     (len_q),
        .is_last (is_last)
    );

    assign cmd_ready  = (state == ST_IDLE);
    assign done_valid = done_q;
    assign done_resp  = resp_q;
    assign done_err   = err_q;

    assign wd_ready   = (state == ST_WDAT) && MEM_WREADY;
    assign MEM_WVALID = (state == ST_WDAT) && wd_valid;
    assign MEM_WDATA  = wd_data;
    assign MEM_WSTRB  = wd_strb;
    assign MEM_WLAST  = (state == ST_WDAT) && is_last;
    assign MEM_BREADY = (state == ST_BRSP);

    assign rd_valid   = (state == ST_RDAT) && MEM_RVALID;
    assign MEM_RREADY = (state == ST_RDAT) && rd_ready;
    assign rd_data    = MEM_RDATA;
    assign rd_last    = (state == ST_RDAT) && is_last;

    assign MEM_AWID    = TXID;
    assign MEM_AWADDR  = addr_q;
    assign MEM_AWLEN   = len_q;
    assign MEM_AWSIZE  = AXSIZE;
    assign MEM_AWBURST = AXI_BURST_INCR;
    assign MEM_AWLOCK  = 1'b0;
    assign MEM_AWCACHE = 4'd0;
    assign MEM_AWPROT  = 3'd0;
    assign MEM_AWQOS   = 4'd0;
    assign MEM_AWVALID = awvalid_q;

    assign MEM_ARID    = TXID;
    assign MEM_ARADDR  = addr_q;
    assign MEM_ARLEN   = len_q;
    assign MEM_ARSIZE  = AXSIZE;
    assign MEM_ARBURST = AXI_BURST_INCR;
    assign MEM_ARLOCK  = 1'b0;
    assign MEM_ARCACHE = 4'd0;
    assign MEM_ARPROT  = 3'd0;
    assign MEM_ARQOS   = 4'd0;
    assign MEM_ARVALID = arvalid_q;

    always_ff @(posedge CLK or negedge RSTn) begin
        if (!RSTn) begin
            state     <= ST_IDLE;
            addr_q    <= '0;
            len_q     <= 8'd0;
            bad_q     <= 1'b0;
            awvalid_q <= 1'b0;
            arvalid_q <= 1'b0;
            done_q    <= 1'b0;
            resp_q    <= AXI_RESP_OKAY;
            err_q     <= 1'b0;
        end else begin
            done_q <= 1'b0;
            case (state)
                ST_IDLE: if (cmd_valid) begin
                    addr_q <= cmd_addr;
                    len_q  <= cmd_len;
                    bad_q  <= cmd_bad;
                    resp_q <= cmd_bad ? AXI_RESP_SLVERR : AXI_RESP_OKAY;
                    err_q  <= cmd_bad;
                    // A rejected command still passes through the address state, VALID held low
                    if (cmd_write) begin
                        state     <= ST_AWR;
                        awvalid_q <= !cmd_bad;
                    end else begin
                        state     <= ST_ARD;
                        arvalid_q <= !cmd_bad;
                    end
                end
                ST_AWR: if (bad_q) begin
                    state  <= ST_DONE;
                    done_q <= 1'b1;
                end else if (MEM_AWREADY) begin
                    awvalid_q <= 1'b0;
                    state     <= ST_WDAT;
                end
                ST_WDAT: if (w_hs && is_last) state <= ST_BRSP;
                ST_BRSP: if (MEM_BVALID) begin
                    resp_q <= MEM_BRESP;
                    err_q  <= (MEM_BID != TXID);
                    state  <= ST_DONE;
                    done_q <= 1'b1;
                end
                ST_ARD: if (bad_q) begin
                    state  <= ST_DONE;
                    done_q <= 1'b1;
                end else if (MEM_ARREADY) begin
                    arvalid_q <= 1'b0;
                    state     <= ST_RDAT;
                end
                ST_RDAT: if (r_hs) begin
                    resp_q <= resp_max(resp_q, MEM_RRESP);
                    if ((MEM_RLAST != is_last) || (MEM_RID != TXID)) err_q <= 1'b1;
                    // The burst ends at len+1 beats whatever RLAST says
                    if (is_last) begin
                        state  <= ST_DONE;
                        done_q <= 1'b1;
                    end
                end
                ST_DONE: state <= ST_IDLE;
                default: state <= ST_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_axi_full_mst_burst.sv
// Directed bench for axi_full_mst_burst with a small zero-wait AXI SRAM responder and fault knobs.
module tb_axi_full_mst_burst;

    logic        CLK = 1'b0;
    logic        RSTn = 1'b0;
    always #5 CLK = ~CLK;

    logic        cmd_valid, cmd_ready, cmd_write;
    logic [31:0] cmd_addr;
    logic [7:0]  cmd_len;
    logic        wd_valid, wd_ready;
    logic [63:0] wd_data;
    logic [7:0]  wd_strb;
    logic        rd_valid, rd_ready, rd_last;
    logic [63:0] rd_data;
    logic        done_valid, done_err;
    logic [1:0]  done_resp;

    logic [3:0]  MEM_AWID, MEM_ARID, MEM_BID, MEM_RID;
    logic [31:0] MEM_AWADDR, MEM_ARADDR;
    logic [7:0]  MEM_AWLEN, MEM_ARLEN;
    logic [2:0]  MEM_AWSIZE, MEM_ARSIZE, MEM_AWPROT, MEM_ARPROT;
    logic [1:0]  MEM_AWBURST, MEM_ARBURST, MEM_BRESP, MEM_RRESP;
    logic        MEM_AWLOCK, MEM_ARLOCK;
    logic [3:0]  MEM_AWCACHE, MEM_ARCACHE, MEM_AWQOS, MEM_ARQOS;
    logic        MEM_AWVALID, MEM_AWREADY, MEM_ARVALID, MEM_ARREADY;
    logic [63:0] MEM_WDATA, MEM_RDATA;
    logic [7:0]  MEM_WSTRB;
    logic        MEM_WLAST, MEM_WVALID, MEM_WREADY;
    logic        MEM_BVALID, MEM_BREADY;
    logic        MEM_RLAST, MEM_RVALID, MEM_RREADY;

    axi_full_mst_burst dut (
        .CLK(CLK), .RSTn(RSTn),
        .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_write(cmd_write),
        .cmd_addr(cmd_addr), .cmd_len(cmd_len),
        .wd_valid(wd_valid), .wd_ready(wd_ready), .wd_data(wd_data), .wd_strb(wd_strb),
        .rd_valid(rd_valid), .rd_ready(rd_ready), .rd_data(rd_data), .rd_last(rd_last),
        .done_valid(done_valid), .done_resp(done_resp), .done_err(done_err),
        .MEM_AWID(MEM_AWID), .MEM_AWADDR(MEM_AWADDR), .MEM_AWLEN(MEM_AWLEN),
        .MEM_AWSIZE(MEM_AWSIZE), .MEM_AWBURST(MEM_AWBURST), .MEM_AWLOCK(MEM_AWLOCK),
        .MEM_AWCACHE(MEM_AWCACHE), .MEM_AWPROT(MEM_AWPROT), .MEM_AWQOS(MEM_AWQOS),
        .MEM_AWVALID(MEM_AWVALID), .MEM_AWREADY(MEM_AWREADY),
        .MEM_WDATA(MEM_WDATA), .MEM_WSTRB(MEM_WSTRB), .MEM_WLAST(MEM_WLAST),
        .MEM_WVALID(MEM_WVALID), .MEM_WREADY(MEM_WREADY),
        .MEM_BID(MEM_BID), .MEM_BRESP(MEM_BRESP), .MEM_BVALID(MEM_BVALID), .MEM_BREADY(MEM_BREADY),
        .MEM_ARID(MEM_ARID), .MEM_ARADDR(MEM_ARADDR), .MEM_ARLEN(MEM_ARLEN),
        .MEM_ARSIZE(MEM_ARSIZE), .MEM_ARBURST(MEM_ARBURST), .MEM_ARLOCK(MEM_ARLOCK),
        .MEM_ARCACHE(MEM_ARCACHE), .MEM_ARPROT(MEM_ARPROT), .MEM_ARQOS(MEM_ARQOS),
        .MEM_ARVALID(MEM_ARVALID), .MEM_ARREADY(MEM_ARREADY),
        .MEM_RID(MEM_RID), .MEM_RDATA(MEM_RDATA), .MEM_RRESP(MEM_RRESP), .MEM_RLAST(MEM_RLAST),
        .MEM_RVALID(MEM_RVALID), .MEM_RREADY(MEM_RREADY)
    );

    // zero-wait SRAM responder, reset together with the DUT
    logic [63:0] mem [0:1023];
    logic [31:0] waddr, raddr;
    logic [7:0]  rlen, rcnt;
    logic        bvalid, rvalid;
    logic [8:0]  inj_rresp_beat = 9'h1FF;
    logic [8:0]  inj_rlast_beat = 9'h1FF;
    logic [3:0]  inj_bid = 4'd0;

    assign MEM_AWREADY = 1'b1;
    assign MEM_WREADY  = 1'b1;
    assign MEM_ARREADY = 1'b1;
    assign MEM_BVALID  = bvalid;
    assign MEM_BRESP   = 2'b00;
    assign MEM_BID     = inj_bid;
    assign MEM_RVALID  = rvalid;
    assign MEM_RID     = 4'd0;
    assign MEM_RDATA   = mem[raddr[12:3]];
    assign MEM_RRESP   = (9'(rcnt) == inj_rresp_beat) ? 2'b10 : 2'b00;
    assign MEM_RLAST   = rvalid && ((rcnt == rlen) || (9'(rcnt) == inj_rlast_beat));

    always @(posedge CLK or negedge RSTn) begin
        if (!RSTn) begin
            waddr <= 32'd0; raddr <= 32'd0; rlen <= 8'd0; rcnt <= 8'd0;
            bvalid <= 1'b0; rvalid <= 1'b0;
        end else begin
            if (MEM_AWVALID && MEM_AWREADY) waddr <= MEM_AWADDR;
            if (MEM_WVALID && MEM_WREADY) begin
                waddr <= waddr + 32'd8;
                if (MEM_WLAST) bvalid <= 1'b1;
            end
            if (bvalid && MEM_BREADY) bvalid <= 1'b0;
            if (MEM_ARVALID && MEM_ARREADY) begin
                raddr <= MEM_ARADDR; rlen <= MEM_ARLEN; rcnt <= 8'd0; rvalid <= 1'b1;
            end else if (rvalid && MEM_RREADY) begin
                if (rcnt == rlen) rvalid <= 1'b0;
                else begin rcnt <= rcnt + 8'd1; raddr <= raddr + 32'd8; end
            end
        end
    end

    always @(posedge CLK)
        if (RSTn && MEM_WVALID && MEM_WREADY)
            for (int b = 0; b < 8; b++)
                if (MEM_WSTRB[b]) mem[waddr[12:3]][b*8 +: 8] <= MEM_WDATA[b*8 +: 8];

    int cyc = 0;
    int aw_cnt = 0;
    int ar_cnt = 0;
    always @(posedge CLK) begin
        cyc <= cyc + 1;
        if (MEM_AWVALID) aw_cnt <= aw_cnt + 1;
        if (MEM_ARVALID) ar_cnt <= ar_cnt + 1;
    end

    int n_chk = 0;
    int n_fail = 0;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    logic [63:0] wbase;
    logic        wlast_log [0:255];
    logic [63:0] rdat [0:255];
    logic        rlst [0:255];
    int          k_w, nb, r_lat, r_extra;
    logic [1:0]  r_resp;
    logic        r_err;

    task automatic run_cmd(input logic w, input logic [31:0] a, input logic [7:0] l, input logic toggle);
        int   n;
        int   tacc;
        logic got;
        @(negedge CLK);
        cmd_valid = 1'b1; cmd_write = w; cmd_addr = a; cmd_len = l;
        #1;
        chk("cmd_ready_idle", 64'(cmd_ready), 64'd1);
        tacc = cyc;
        @(negedge CLK);
        cmd_valid = 1'b0;
        k_w = 0; nb = 0; got = 1'b0; n = 0; r_extra = 0;
        while (!got && n < 1000) begin
            if (done_valid) begin
                got = 1'b1; r_resp = done_resp; r_err = done_err; r_lat = cyc - tacc;
            end else begin
                if (w) begin
                    wd_valid = (k_w <= int'(l));
                    wd_data  = 64'(k_w + 1) * wbase;
                    wd_strb  = 8'hFF;
                    #1;
                    if (wd_valid && wd_ready) begin wlast_log[k_w] = MEM_WLAST; k_w++; end
                end else begin
                    rd_ready = toggle ? ((n % 2) == 0) : 1'b1;
                    #1;
                    if (rd_valid && rd_ready) begin rdat[nb] = rd_data; rlst[nb] = rd_last; nb++; end
                end
                @(negedge CLK);
                n++;
            end
        end
        wd_valid = 1'b0; rd_ready = 1'b0;
        chk("done_seen", 64'(got), 64'd1);
        repeat (3) begin
            @(negedge CLK);
            if (done_valid) r_extra++;
        end
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int a0;
        cmd_valid = 0; cmd_write = 0; cmd_addr = 0; cmd_len = 0;
        wd_valid = 0; wd_data = 0; wd_strb = 0; rd_ready = 0; wbase = 64'h11;
        repeat (2) @(negedge CLK);
        chk("rst_cmd_ready", 64'(cmd_ready), 64'd1);
        chk("rst_awvalid", 64'(MEM_AWVALID), 64'd0);
        chk("rst_arvalid", 64'(MEM_ARVALID), 64'd0);
        chk("rst_bready", 64'(MEM_BREADY), 64'd0);
        chk("rst_rready", 64'(MEM_RREADY), 64'd0);
        chk("rst_done", 64'({done_valid, done_resp, done_err}), 64'd0);
        RSTn = 1'b1;
        @(negedge CLK);
        wd_valid = 1'b1; #1;
        chk("idle_wd_ready", 64'(wd_ready), 64'd0);
        chk("idle_wvalid", 64'(MEM_WVALID), 64'd0);
        wd_valid = 1'b0;

        // T1: 4-beat write
        wbase = 64'h11;
        run_cmd(1'b1, 32'h8000_0000, 8'd3, 1'b0);
        chk("t1_beats", 64'(k_w), 64'd4);
        for (int i = 0; i < 4; i++) chk("t1_wlast", 64'(wlast_log[i]), 64'(i == 3));
        chk("t1_resp", 64'(r_resp), 64'd0);
        chk("t1_err", 64'(r_err), 64'd0);
        chk("t1_lat", 64'(r_lat), 64'd7);
        for (int i = 0; i < 4; i++) chk("t1_mem", mem[i], 64'(i + 1) * 64'h11);

        // T2: read back
        run_cmd(1'b0, 32'h8000_0000, 8'd3, 1'b0);
        chk("t2_beats", 64'(nb), 64'd4);
        for (int i = 0; i < 4; i++) begin
            chk("t2_data", rdat[i], 64'(i + 1) * 64'h11);
            chk("t2_rlast", 64'(rlst[i]), 64'(i == 3));
        end
        chk("t2_resp", 64'(r_resp), 64'd0);

        // T3: 8-beat read with rd_ready toggling
        wbase = 64'h0101_0101_0000_0001;
        run_cmd(1'b1, 32'h8000_0100, 8'd7, 1'b0);
        run_cmd(1'b0, 32'h8000_0100, 8'd7, 1'b1);
        chk("t3_beats", 64'(nb), 64'd8);
        for (int i = 0; i < 8; i++) chk("t3_data", rdat[i], 64'(i + 1) * 64'h0101_0101_0000_0001);
        chk("t3_rlast", 64'(rlst[7]), 64'd1);
        chk("t3_single_done", 64'(r_extra), 64'd0);
        chk("t3_err", 64'(r_err), 64'd0);

        // T4: 4KB crossing, misalignment, exact-fit boundary
        a0 = aw_cnt;
        run_cmd(1'b1, 32'h8000_0FF8, 8'd1, 1'b0);
        chk("t4_no_aw", 64'(aw_cnt - a0), 64'd0);
        chk("t4_no_w", 64'(k_w), 64'd0);
        chk("t4_lat", 64'(r_lat), 64'd2);
        chk("t4_resp", 64'(r_resp), 64'd2);
        chk("t4_err", 64'(r_err), 64'd1);
        a0 = ar_cnt;
        run_cmd(1'b0, 32'h8000_0004, 8'd0, 1'b0);
        chk("t4_align_no_ar", 64'(ar_cnt - a0), 64'd0);
        chk("t4_align_resp", 64'({r_resp, r_err}), 64'b101);
        wbase = 64'h5A;
        run_cmd(1'b1, 32'h8000_0FF0, 8'd1, 1'b0);
        chk("t4_fit_beats", 64'(k_w), 64'd2);
        chk("t4_fit_resp", 64'({r_resp, r_err}), 64'b000);
        chk("t4_fit_lat", 64'(r_lat), 64'd5);

        // T5: SLVERR mid-burst, early RLAST, wrong BID
        inj_rresp_beat = 9'd1;
        run_cmd(1'b0, 32'h8000_0000, 8'd3, 1'b0);
        chk("t5_slverr_resp", 64'(r_resp), 64'd2);
        chk("t5_slverr_err", 64'(r_err), 64'd0);
        chk("t5_slverr_beats", 64'(nb), 64'd4);
        inj_rresp_beat = 9'h1FF;
        inj_rlast_beat = 9'd0;
        run_cmd(1'b0, 32'h8000_0000, 8'd3, 1'b0);
        chk("t5_rlast_err", 64'(r_err), 64'd1);
        chk("t5_rlast_beats", 64'(nb), 64'd4);
        chk("t5_rlast_resp", 64'(r_resp), 64'd0);
        inj_rlast_beat = 9'h1FF;
        inj_bid = 4'd3;
        run_cmd(1'b1, 32'h8000_0200, 8'd0, 1'b0);
        chk("t5_bid_err", 64'(r_err), 64'd1);
        inj_bid = 4'd0;

        // T6: reset during W beat 2 of an 8-beat write
        @(negedge CLK);
        cmd_valid = 1'b1; cmd_write = 1'b1; cmd_addr = 32'h8000_0400; cmd_len = 8'd7;
        @(negedge CLK);
        cmd_valid = 1'b0;
        @(negedge CLK);
        wd_valid = 1'b1; wd_data = 64'd1; wd_strb = 8'hFF;
        @(negedge CLK);
        wd_data = 64'd2;
        #1;
        chk("t6_in_wdat", 64'(wd_ready), 64'd1);
        #1 RSTn = 1'b0;
        #1;
        chk("t6_awvalid", 64'(MEM_AWVALID), 64'd0);
        chk("t6_wvalid", 64'(MEM_WVALID), 64'd0);
        chk("t6_arvalid", 64'(MEM_ARVALID), 64'd0);
        chk("t6_cmd_ready", 64'(cmd_ready), 64'd1);
        chk("t6_done", 64'(done_valid), 64'd0);
        wd_valid = 1'b0;
        @(negedge CLK);
        RSTn = 1'b1;
        wbase = 64'hC0FFEE;
        run_cmd(1'b1, 32'h8000_0300, 8'd0, 1'b0);
        chk("t6_after_resp", 64'({r_resp, r_err}), 64'b000);
        chk("t6_after_lat", 64'(r_lat), 64'd4);
        chk("t6_after_mem", mem[96], 64'hC0FFEE);

        $display("TB_RESULT checks=%0d failures=%0d", n_chk, n_fail);
        $finish;
    end

endmodule
